// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NUM_REQ requesters.
// Runs one transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req/i_addr/i_write/i_wdata
//                             per-requester request level and payload (32-bit slices)
//   o_grant                   one-hot owner of the current transaction, 0 when idle
//   o_ack                     one-hot single-cycle completion pulse
//   o_rdata                   captured read data, valid while o_ack != 0
//   o_timeout                 sticky flag: a WAIT lasted MAX_LATENCY cycles
//   m_start/m_addr/m_write/m_wdata
//                             command to the APB master
//   m_done/m_rdata            completion pulse and read data from the APB master
module apb_rr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_LATENCY = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [32*NUM_REQ-1:0]   i_addr,
  input  logic [NUM_REQ-1:0]      i_write,
  input  logic [32*NUM_REQ-1:0]   i_wdata,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_REQ-1:0]      o_ack,
  output logic [31:0]             o_rdata,
  output logic                    o_timeout,
  output logic                    m_start,
  output logic [31:0]             m_addr,
  output logic                    m_write,
  output logic [31:0]             m_wdata,
  input  logic                    m_done,
  input  logic [31:0]             m_rdata
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                timeout_q, timeout_d;
  logic                start_q, start_d;
  logic [31:0]         addr_q, addr_d;
  logic                write_q, write_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  // Round-robin search: first set request at or above the pointer, wrapping.
  logic                found;
  logic [PtrW-1:0]     win_idx;
  logic [PtrW:0]       cand;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(NUM_REQ)) begin
        cand = cand - (PtrW+1)'(NUM_REQ);
      end
      if (!found && i_req[cand[PtrW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = '0;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    start_d   = 1'b0;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          addr_d           = i_addr[32*int'(win_idx) +: 32];
          write_d          = i_write[win_idx];
          wdata_d          = i_wdata[32*int'(win_idx) +: 32];
          ptr_d            = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          // Start is registered here so it is high during the ISSUE cycle.
          start_d          = 1'b1;
          state_d          = StIssue;
        end
      end
      StIssue: begin
        // m_done is ignored here, even if it coincides with m_start.
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (m_done) begin
          rdata_d = m_rdata;
          ack_d   = grant_q;
          state_d = StResp;
        end else begin
          if (cnt_q != CntW'(MAX_LATENCY)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_d == CntW'(MAX_LATENCY)) begin
            timeout_d = 1'b1;
          end
        end
      end
      StResp: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_ack     = ack_q;
  assign o_rdata   = rdata_q;
  assign o_timeout = timeout_q;
  assign m_start   = start_q;
  assign m_addr    = addr_q;
  assign m_write   = write_q;
  assign m_wdata   = wdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter (NUM_REQ=4, MAX_LATENCY=16).
module tb_apb_rr_arbiter;

  localparam int NR = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     i_req;
  logic [32*NR-1:0]  i_addr;
  logic [NR-1:0]     i_write;
  logic [32*NR-1:0]  i_wdata;
  logic [NR-1:0]     o_grant;
  logic [NR-1:0]     o_ack;
  logic [31:0]       o_rdata;
  logic              o_timeout;
  logic              m_start;
  logic [31:0]       m_addr;
  logic              m_write;
  logic [31:0]       m_wdata;
  logic              m_done;
  logic [31:0]       m_rdata;

  int errors = 0;
  int checks = 0;

  apb_rr_arbiter #(
    .NUM_REQ    (NR),
    .MAX_LATENCY(16)
  ) u_dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_write  (i_write),
    .i_wdata  (i_wdata),
    .o_grant  (o_grant),
    .o_ack    (o_ack),
    .o_rdata  (o_rdata),
    .o_timeout(o_timeout),
    .m_start  (m_start),
    .m_addr   (m_addr),
    .m_write  (m_write),
    .m_wdata  (m_wdata),
    .m_done   (m_done),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction for requester k, expected to win the next arbitration.
  task automatic run_txn(input int k, input logic [31:0] rd, input bit rereq);
    logic [NR-1:0] exp;
    exp    = '0;
    exp[k] = 1'b1;
    for (int n = 0; n < 10 && o_grant == '0; n++) step();
    check_eq("grant", 32'(o_grant), 32'(exp));
    check_eq("m_start", 32'(m_start), 32'd1);
    check_eq("m_addr", m_addr, 32'h100 + 32'(k));
    step();
    step();
    m_done  = 1'b1;
    m_rdata = rd;
    step();
    m_done  = 1'b0;
    check_eq("ack", 32'(o_ack), 32'(exp));
    check_eq("rdata", o_rdata, rd);
    i_req[k] = 1'b0;
    step();
    check_eq("grant_idle", 32'(o_grant), 32'd0);
    if (rereq) i_req[k] = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    i_req   = '0;
    i_write = '0;
    i_wdata = '0;
    m_done  = 1'b0;
    m_rdata = '0;
    for (int k = 0; k < NR; k++) i_addr[32*k +: 32] = 32'h100 + 32'(k);
    step();
    step();
    rst = 1'b0;

    // Reset values
    check_eq("rst_grant", 32'(o_grant), 32'd0);
    check_eq("rst_ack", 32'(o_ack), 32'd0);
    check_eq("rst_rdata", o_rdata, 32'd0);
    check_eq("rst_timeout", 32'(o_timeout), 32'd0);
    check_eq("rst_m_start", 32'(m_start), 32'd0);
    check_eq("rst_m_addr", m_addr, 32'd0);
    check_eq("rst_m_write", 32'(m_write), 32'd0);
    check_eq("rst_m_wdata", m_wdata, 32'd0);

    // Single read from requester 2
    i_addr[64 +: 32] = 32'h40;
    i_req[2] = 1'b1;
    step();
    check_eq("rd_grant", 32'(o_grant), 32'h4);
    check_eq("rd_m_start", 32'(m_start), 32'd1);
    check_eq("rd_m_addr", m_addr, 32'h40);
    check_eq("rd_m_write", 32'(m_write), 32'd0);
    step();
    check_eq("rd_start_pulse", 32'(m_start), 32'd0);
    step();
    step();
    m_done  = 1'b1;
    m_rdata = 32'hDEADBEEF;
    step();
    m_done  = 1'b0;
    check_eq("rd_ack", 32'(o_ack), 32'h4);
    check_eq("rd_rdata", o_rdata, 32'hDEADBEEF);
    i_req[2] = 1'b0;
    i_addr[64 +: 32] = 32'h102;
    step();
    check_eq("rd_ack_clr", 32'(o_ack), 32'd0);
    check_eq("rd_grant_clr", 32'(o_grant), 32'd0);
    check_eq("rd_addr_hold", m_addr, 32'h40);

    // Pointer wrap: pointer now 3, req 1001 -> 3 then 0
    i_req = 4'b1001;
    run_txn(3, 32'h33333333, 1'b0);
    run_txn(0, 32'h00000011, 1'b0);

    // Write from requester 0 (pointer 1); payload changed after grant
    i_addr[0 +: 32]  = 32'h10;
    i_wdata[0 +: 32] = 32'h1234;
    i_write[0] = 1'b1;
    i_req[0]   = 1'b1;
    step();
    check_eq("wr_grant", 32'(o_grant), 32'h1);
    check_eq("wr_m_write", 32'(m_write), 32'd1);
    check_eq("wr_m_wdata", m_wdata, 32'h1234);
    check_eq("wr_m_addr", m_addr, 32'h10);
    i_wdata[0 +: 32] = 32'h0;
    i_addr[0 +: 32]  = 32'h100;
    i_write[0] = 1'b0;
    m_done  = 1'b1;           // coincides with m_start: must be ignored
    m_rdata = 32'h5555;
    step();
    m_done  = 1'b0;
    check_eq("wr_early_done_ack", 32'(o_ack), 32'd0);
    check_eq("wr_early_done_rdata", o_rdata, 32'h00000011);
    step();
    step();
    check_eq("wr_wdata_wait", m_wdata, 32'h1234);
    m_done  = 1'b1;
    m_rdata = 32'h0;
    step();
    m_done  = 1'b0;
    check_eq("wr_ack", 32'(o_ack), 32'h1);
    check_eq("wr_wdata_resp", m_wdata, 32'h1234);
    check_eq("wr_write_resp", 32'(m_write), 32'd1);
    check_eq("wr_addr_resp", m_addr, 32'h10);
    i_req[0] = 1'b0;
    step();
    check_eq("wr_grant_clr", 32'(o_grant), 32'd0);
    check_eq("wr_wdata_idle", m_wdata, 32'h1234);

    // Timeout: requester 1, withhold m_done
    i_req[1] = 1'b1;
    step();
    check_eq("to_grant", 32'(o_grant), 32'h2);
    step();
    for (int n = 0; n < 15; n++) step();
    check_eq("to_before", 32'(o_timeout), 32'd0);
    step();
    check_eq("to_at16", 32'(o_timeout), 32'd1);
    step();
    step();
    step();
    check_eq("to_sat", 32'(o_timeout), 32'd1);
    m_done  = 1'b1;
    m_rdata = 32'hCAFEF00D;
    step();
    m_done  = 1'b0;
    check_eq("to_ack", 32'(o_ack), 32'h2);
    check_eq("to_rdata", o_rdata, 32'hCAFEF00D);
    i_req[1] = 1'b0;
    step();
    check_eq("to_sticky", 32'(o_timeout), 32'd1);

    // Reset mid-WAIT (requester 3, pointer 2)
    i_req[3] = 1'b1;
    step();
    check_eq("rw_grant", 32'(o_grant), 32'h8);
    step();
    step();
    i_req = '0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
    check_eq("rw_grant0", 32'(o_grant), 32'd0);
    check_eq("rw_timeout0", 32'(o_timeout), 32'd0);
    check_eq("rw_rdata0", o_rdata, 32'd0);
    check_eq("rw_m_addr0", m_addr, 32'd0);
    check_eq("rw_m_start0", 32'(m_start), 32'd0);
    m_done  = 1'b1;
    m_rdata = 32'hAAAA5555;
    step();
    m_done  = 1'b0;
    check_eq("rw_no_ack", 32'(o_ack), 32'd0);
    check_eq("rw_no_rdata", o_rdata, 32'd0);
    check_eq("rw_no_grant", 32'(o_grant), 32'd0);

    // Contention from pointer 0: order 0,1,2,3,0
    i_req = 4'b1111;
    run_txn(0, 32'hA0, 1'b1);
    run_txn(1, 32'hA1, 1'b1);
    run_txn(2, 32'hA2, 1'b1);
    run_txn(3, 32'hA3, 1'b1);
    run_txn(0, 32'hB0, 1'b0);
    i_req = '0;
    step();
    check_eq("end_grant", 32'(o_grant), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
